serial_add_sequencer: RTL and testbench

//  Host-side partner of the bit-serial adder. Accepts two parallel W-bit operands on a valid/ready handshake.

---
 rtl/serseq_pkg.sv | 23 ++
 rtl/serseq_sipo.sv | 25 ++
 rtl/serial_add_sequencer.sv | 166 ++++++++++++++++
 tb/tb_serial_add_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serseq_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and overflow helper.
package serseq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StClear = ST_CLEAR,
        StShift = ST_SHIFT,
        StDrain = ST_DRAIN,
        StDone  = ST_DONE
    } state_e;

    function automatic logic sum_ovf(input logic a_sign, input logic b_sign,
                                     input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

endpackage

// File: rtl/serseq_sipo.sv
// Serial-in/parallel-out collector: fills LSB-first, each new bit enters at the MSB.
module serseq_sipo #(
    parameter int unsigned N = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         shift_en_i,
    input  logic         bit_i,
    output logic [N-1:0] data_o
);

    logic [N-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            data_q <= '0;
        end else if (shift_en_i) begin
            data_q <= {bit_i, data_q[N-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/serial_add_sequencer.sv
// Host-side sequencer for a bit-serial adder: parallel operands in, serial stream out/in,
// parallel sum+carry back. Define SERSEQ_OVF_EN to enable the signed-overflow flag.
module serial_add_sequencer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         adder_rst_n,
    output logic         ser_in1,
    output logic         ser_in2,
    input  logic         ser_sum,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic         res_ovf
);

    import serseq_pkg::*;

    localparam int unsigned CW = $clog2(W + 2);
    localparam logic [CW-1:0] CntLast = CW'(W);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic          op_ready_q, op_ready_d;
    logic          res_valid_q, res_valid_d;
    logic          run_q, run_d;
    logic          ser_in1_q, ser_in1_d, ser_in2_q, ser_in2_d;
    logic          op_fire, res_fire;
    logic          sipo_clr, sipo_shift;
    logic [W:0]    sipo_data;

    assign op_fire  = op_valid & op_ready_q;
    assign res_fire = res_valid_q & res_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            StIdle: begin
                if (op_fire) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    a_d     = op_a;
                    b_d     = op_b;
                end
            end
            StClear: begin
                state_d = StShift;
                cnt_d   = '0;
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: state_d = StDone;
            StDone: begin
                if (res_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Serial bits are registered, so they are chosen from the state being entered.
        ser_in1_d = 1'b0;
        ser_in2_d = 1'b0;
        if (state_d == StShift && cnt_d != CntLast) begin
            ser_in1_d = a_q[0];
            ser_in2_d = b_q[0];
            a_d       = a_q >> 1;
            b_d       = b_q >> 1;
        end

        op_ready_d  = (state_d == StIdle);
        res_valid_d = (state_d == StDone);
        run_d       = (state_d == StShift) || (state_d == StDrain);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            run_q       <= 1'b0;
            ser_in1_q   <= 1'b0;
            ser_in2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            run_q       <= run_d;
            ser_in1_q   <= ser_in1_d;
            ser_in2_q   <= ser_in2_d;
        end
    end

    // Sum bit k appears on ser_sum one cycle after it is driven; the extra DRAIN shift takes carry.
    assign sipo_clr   = (state_q == StClear);
    assign sipo_shift = ((state_q == StShift) && (cnt_q != '0)) || (state_q == StDrain);

    serseq_sipo #(
        .N(W + 1)
    ) u_sipo (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (sipo_clr),
        .shift_en_i(sipo_shift),
        .bit_i     (ser_sum),
        .data_o    (sipo_data)
    );

`ifdef SERSEQ_OVF_EN
    logic a_sign_q, b_sign_q, ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (op_fire) begin
                a_sign_q <= op_a[W-1];
                b_sign_q <= op_b[W-1];
            end
            // In DRAIN the sum MSB has just reached the top of the collector.
            if (state_q == StClear) begin
                ovf_q <= 1'b0;
            end else if (state_q == StDrain) begin
                ovf_q <= sum_ovf(a_sign_q, b_sign_q, sipo_data[W]);
            end
        end
    end

    assign res_ovf = ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

    // Reset forces the adder into clear within the very cycle it is asserted.
    assign adder_rst_n = run_q & ~reset;
    assign ser_in1     = ser_in1_q & ~reset;
    assign ser_in2     = ser_in2_q & ~reset;
    assign op_ready    = op_ready_q;
    assign res_valid   = res_valid_q;
    assign res_sum     = sipo_data[W-1:0];
    assign res_cout    = sipo_data[W];

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer (W=8) with a behavioural bit-serial adder model.
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;
    localparam int LatExp = 11;
    localparam int IntervalExp = 12;
`ifdef SERSEQ_OVF_EN
    localparam bit OvfOn = 1'b1;
`else
    localparam bit OvfOn = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         adder_rst_n;
    logic         ser_in1, ser_in2;
    logic         ser_sum;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ovf;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic vprev = 1'b0;
    exp_t exp_q[$];
    int   lat_q[$];

    logic carry = 1'b0;
    logic adder_out = 1'b0;

    serial_add_sequencer #(
        .W(W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .adder_rst_n(adder_rst_n),
        .ser_in1    (ser_in1),
        .ser_in2    (ser_in2),
        .ser_sum    (ser_sum),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_ovf    (res_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial adder with registered output and carry, cleared by active-low reset.
    always @(posedge clk) begin
        if (!adder_rst_n) begin
            carry     <= 1'b0;
            adder_out <= 1'b0;
        end else begin
            adder_out <= ser_in1 ^ ser_in2 ^ carry;
            carry     <= (ser_in1 & ser_in2) | (carry & (ser_in1 ^ ser_in2));
        end
    end
    assign ser_sum = adder_out;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es,
                         input logic ec, input logic eo, input bit push, output int acc);
        int n;
        exp_t e;
        n = 0;
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            fail_now("issue_timeout");
            op_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (push) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo & OvfOn;
            exp_q.push_back(e);
            lat_q.push_back(acc);
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("result_timeout");
        @(negedge clk);
    endtask

    // Monitor: samples just after the negedge so bench-driven res_ready has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (res_valid && !vprev) begin
                    if (lat_q.size() == 0) fail_now("latency_unexpected");
                    else check("latency", 32'(cyc - lat_q.pop_front()), 32'(LatExp));
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        check("res_sum", 32'(res_sum), 32'(e.sum));
                        check("res_cout", 32'(res_cout), 32'(e.cout));
                        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
                    end
                end
            end
            vprev = res_valid;
        end
    end

    initial begin
        int acc;
        int acc1;
        int n;
        repeat (3) @(negedge clk);
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_cout", 32'(res_cout), 32'd0);
        check("rst_res_ovf", 32'(res_ovf), 32'd0);
        check("rst_adder_rst_n", 32'(adder_rst_n), 32'd0);
        check("rst_ser_in", 32'({ser_in1, ser_in2}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b1, acc);
        wait_drain();
        issue(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, acc);
        wait_drain();
        issue(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, acc);
        wait_drain();

        // Consumer stalls in DONE; extra op_valid pulses must be ignored.
        res_ready = 1'b0;
        issue(8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b1, acc);
        n = 0;
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) fail_now("stall_wait");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_sum", 32'(res_sum), 32'h46);
            check("stall_op_ready", 32'(op_ready), 32'd0);
            op_a = 8'hFF;
            op_b = 8'hFF;
            op_valid = (i % 2 == 0);
            @(negedge clk);
        end
        op_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("post_hs_op_ready", 32'(op_ready), 32'd1);
        check("post_hs_res_valid", 32'(res_valid), 32'd0);
        repeat (15) @(negedge clk);
        check("idle_op_ready", 32'(op_ready), 32'd1);

        // Abort during SHIFT k=4.
        issue(8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        repeat (5) @(negedge clk);
        check("k4_adder_running", 32'(adder_rst_n), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_adder_rst_n", 32'(adder_rst_n), 32'd0);
        check("abort_ser_in", 32'({ser_in1, ser_in2}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_op_ready", 32'(op_ready), 32'd1);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_sum", 32'(res_sum), 32'd0);
        issue(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1, acc);
        wait_drain();

        // Back-to-back with the consumer always ready.
        issue(8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, acc1);
        n = 0;
        while (!op_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("issue_interval", 32'(cyc - acc1), 32'(IntervalExp));
        issue(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, acc);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
